// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (M) writeback,
// with a registered write stage and a 32-entry pending-write scoreboard. Optional macro: REGWR_XZR_FILTER_EN.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [4:0]            a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic [4:0]            m_addr,
  input  logic [DATA_WIDTH-1:0] m_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_addr,
  output logic                  regwrite,
  output logic [4:0]            wraddr,
  output logic [DATA_WIDTH-1:0] wrdata,
  output logic [31:0]           pending,
  output logic                  prio_m
);

  // Handshake: a request transfers on a cycle where *_valid and *_ready are both 1;
  // the requester holds valid/addr/data stable until then. Ready is combinational from valid.

  logic                  r_regwrite;
  logic [4:0]            r_wraddr;
  logic [DATA_WIDTH-1:0] r_wrdata;
  logic [31:0]           r_pending;
  logic                  r_prio_m;

  logic                  w_grant_a;
  logic                  w_grant_m;
  logic                  w_grant;
  logic                  w_contention;
  logic [4:0]            w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_write;
  logic                  w_issue;
  logic [31:0]           w_set_mask;
  logic [31:0]           w_clr_mask;

  always_comb begin
    w_contention = a_valid & m_valid;
    w_grant_m    = ~reset & m_valid & (~a_valid | r_prio_m);
    w_grant_a    = ~reset & a_valid & (~m_valid | ~r_prio_m);
    w_grant      = w_grant_a | w_grant_m;
    w_gnt_addr   = w_grant_m ? m_addr : a_addr;
    w_gnt_data   = w_grant_m ? m_data : a_data;
`ifdef REGWR_XZR_FILTER_EN
    // Register 31 is the zero register: writes and issues to it are swallowed.
    w_write      = w_grant & (w_gnt_addr != 5'd31);
    w_issue      = issue_valid & (issue_addr != 5'd31);
`else
    w_write      = w_grant;
    w_issue      = issue_valid;
`endif
    w_set_mask   = '0;
    w_clr_mask   = '0;
    if (w_issue) w_set_mask[issue_addr] = 1'b1;
    if (w_write) w_clr_mask[w_gnt_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_wraddr   <= '0;
      r_wrdata   <= '0;
      r_pending  <= '0;
      r_prio_m   <= 1'b1;
    end else begin
      r_regwrite <= w_write;
      if (w_write) begin
        r_wraddr <= w_gnt_addr;
        r_wrdata <= w_gnt_data;
      end
      // Loser of a contended grant gets priority next time.
      if (w_grant && w_contention) r_prio_m <= w_grant_a;
      // Set after clear: a new producer of the same register stays outstanding.
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign a_ready  = w_grant_a;
  assign m_ready  = w_grant_m;
  assign regwrite = r_regwrite;
  assign wraddr   = r_wraddr;
  assign wrdata   = r_wrdata;
  assign pending  = r_pending;
  assign prio_m   = r_prio_m;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between the execute-stage writeback (A) and the load/memory writeback (M) using round-robin arbitration. Drives the `regwrite`, `wraddr` and `wrdata` inputs of the 5-to-32 write-enable decoder and the register file. Keeps a 32-entry pending-write scoreboard for hazard detection in the pipeline.

## Interface
- `DATA_WIDTH`, default 64: width of the write data.
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  ALU writeback request.
- `a_ready`  out  1  A request granted this cycle.
- `a_addr`  in  5  A destination register.
- `a_data`  in  DATA_WIDTH  A write data.
- `m_valid`, `m_ready`, `m_addr`, `m_data`: same as the A ports, for load writeback.
- `issue_valid`  in  1  an instruction that writes a register is issued.
- `issue_addr`  in  5  destination of the issued instruction.
- `regwrite`  out  1  register-file write enable, to the decoder.
- `wraddr`  out  5  register-file write address.
- `wrdata`  out  DATA_WIDTH  register-file write data.
- `pending`  out  32  bit i = 1 while a write to register i is outstanding.
- `prio_m`  out  1  round-robin pointer; 1 means M wins the next contention.

## Operation
- Grant logic is combinational from `*_valid` and `prio_m`.
  - Only one requester valid: that requester is granted.
  - Both valid: M is granted if `prio_m`=1, else A.
  - Neither valid: no grant.
- `a_ready` = grant to A; `m_ready` = grant to M. Both are 0 while `reset`=1.
- A handshake completes in a cycle where valid and ready are both 1.
- A requester holds valid, addr and data stable until its ready is asserted.
- Pointer update:
  - Toggles only on a grant made under contention, so the loser wins next time.
  - A single-requester grant leaves the pointer unchanged.
  - Two consecutive contention cycles therefore alternate M, A, M, ...
- Output stage is registered.
  - On a grant, the next edge loads `regwrite`=1 and the granted addr and data into `wraddr` and `wrdata`.
  - With no grant, `regwrite`=0 and `wraddr`/`wrdata` hold their last values.
- Scoreboard:
  - `pending[issue_addr]` sets at the edge where `issue_valid`=1.
  - `pending[x]` clears at the edge where a grant to address x is registered.
  - Set and clear of the same bit on the same edge: set wins, because the new producer stays outstanding.
  - Different bits set and cleared on the same edge are independent.
- Reset values: `regwrite`=0, `wraddr`=0, `wrdata`=0, `pending`=0, `prio_m`=1.
- Reset mid-operation: in-flight requests are dropped and no handshake completes. Requesters re-present their requests after reset deasserts.

## Timing
- Grant to `regwrite` high: 1 cycle. Sustained throughput: one write per cycle.
- Under continuous contention each requester gets one grant every 2 cycles.
- A grant's `pending` clear and its `regwrite` assertion occur on the same edge.
- An issue to register x on cycle t is visible on `pending[x]` at t+1.
- `pending` is a register output; it has no combinational path from inputs.
- `*_ready` is combinational from `*_valid`. The ready/valid path is the only combinational input-to-output path.

## Configuration
- `REGWR_XZR_FILTER_EN` defined (XZR handling):
  - A grant to address 31 completes the handshake and updates the pointer, but `regwrite` stays 0 and `wraddr`/`wrdata` hold.
  - `issue_valid` with `issue_addr`=31 is ignored, so `pending[31]` stays 0.
- Not defined: address 31 is handled like any other register, with a normal write and normal pending tracking.

## Test plan
- After reset: `regwrite`=0, `pending`=0, `prio_m`=1. Then `a_valid`=1, `a_addr`=5, `a_data`=0x1234 -> `a_ready`=1 in the same cycle; next cycle `regwrite`=1, `wraddr`=5, `wrdata`=0x1234; `prio_m` still 1.
- A (addr 3) and M (addr 7) both valid for 4 cycles with `prio_m`=1 -> grants in order M, A, M, A; `regwrite`=1 with `wraddr` 7, 3, 7, 3 one cycle later; `prio_m` ends at 1.
- Issue to reg 9 at cycle 0 -> `pending[9]`=1 at cycle 1. M writes reg 9 at cycle 2 while issue to reg 9 also occurs -> `pending[9]` stays 1. M writes reg 9 again at cycle 4 with no issue -> `pending[9]`=0 at cycle 5.
- Addr 31 with `REGWR_XZR_FILTER_EN` defined: A request to 31 -> `a_ready`=1, `regwrite` stays 0, and issue to 31 leaves `pending[31]`=0. Without the macro: `regwrite`=1, `wraddr`=31, and `pending[31]` sets and clears normally.
- Reset mid-stream: `reset`=1 while both requesters are valid -> both readies are 0, and one cycle later `regwrite`=0, `pending`=0, `prio_m`=1. After reset deasserts with both still valid, M is granted first.
